// File: rtl/bram_stream_reader.sv
// Burst read client for one dp_bram port: issues credit-limited sequential reads
// and returns the words as a valid/ready stream with a last flag.
module bram_stream_reader #(
  parameter int W          = 128,
  parameter int AW         = 10,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   base_addr,
  input  logic [AW:0]     count,
  output logic            busy,
  output logic            done,
  output logic            mem_en,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [W/8-1:0]  mem_be,
  output logic [W-1:0]    mem_din,
  input  logic [W-1:0]    mem_dout,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_data,
  output logic            m_last,
  output logic [1:0]      state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("bram_stream_reader: FIFO_DEPTH must be at least 2");
  end
  if (RD_LAT < 1) begin : g_bad_lat
    $error("bram_stream_reader: RD_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]     addr_q;
  logic [AW:0]       issue_left;
  logic [AW:0]       count_q;
  logic [AW:0]       out_cnt;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     fifo_cnt;
  logic [RD_LAT-1:0] rd_sr;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [W-1:0]      fifo_mem [FIFO_DEPTH];
  logic              done_q;

  logic accept, zero_cmd, issue, push, pop, last_word;

  // Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
  // once m_valid rises, m_data and m_last hold until that transfer.
  assign accept    = (state == IDLE) && start && (count != '0);
  assign zero_cmd  = (state == IDLE) && start && (count == '0);
  assign issue     = (state == ISSUE) && (credits < CW'(FIFO_DEPTH));
  assign push      = rd_sr[RD_LAT-1];
  assign pop       = m_valid && m_ready;
  assign last_word = (out_cnt == (count_q - (AW+1)'(1)));

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign mem_en    = issue;
  assign mem_addr  = addr_q;
  assign mem_we    = 1'b0;
  assign mem_be    = '0;
  assign mem_din   = '0;
  assign m_valid   = (fifo_cnt != '0);
  assign m_data    = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_last    = m_valid && last_word;
  assign state_dbg = state;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   if (issue && (issue_left == (AW+1)'(1))) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      issue_left <= '0;
      count_q    <= '0;
      out_cnt    <= '0;
      credits    <= '0;
      fifo_cnt   <= '0;
      rd_sr      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= zero_cmd || ((state == DRAIN) && pop && m_last);

      if (accept) begin
        addr_q     <= base_addr;
        issue_left <= count;
        count_q    <= count;
      end else if (issue) begin
        addr_q     <= addr_q + AW'(1);
        issue_left <= issue_left - (AW+1)'(1);
      end

      if (accept)   out_cnt <= '0;
      else if (pop) out_cnt <= out_cnt + (AW+1)'(1);

      // A credit covers a read from issue until its word leaves the FIFO.
      credits  <= credits + CW'(issue) - CW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);

      rd_sr[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) rd_sr[i] <= rd_sr[i-1];

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage needs no reset: m_data is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

endmodule
